// File: rtl/reg_writeback_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : reg_writeback_ctrl_pkg
// Brief   : Shared encodings for the register-file writeback path.
// Rev     : 1.0  initial release
// ============================================================================
package reg_writeback_ctrl_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   localparam logic [ADDR_W-1:0] REG_RA = 5'd31;

   typedef enum logic [1:0] {
      DST_RT   = 2'b00,
      DST_RD   = 2'b01,
      DST_RA   = 2'b10,
      DST_NONE = 2'b11
   } dst_sel_e;

   typedef enum logic [1:0] {
      SRC_ALU  = 2'b00,
      SRC_MEM  = 2'b01,
      SRC_PC4  = 2'b10,
      SRC_ZERO = 2'b11
   } src_sel_e;

endpackage
`default_nettype wire

// File: rtl/reg_writeback_ctrl_wb_queue.sv
`default_nettype none
// ============================================================================
// Module  : wb_queue
// Brief   : In-order queue of {addr, data} writeback entries with flush.
// Rev     : 1.0  initial release
// ============================================================================
module wb_queue
   import reg_writeback_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_push,
   input  logic                      i_pop,
   input  logic                      i_flush,
   input  logic [ADDR_W-1:0]         i_addr,
   input  logic [DATA_W-1:0]         i_data,
   output logic [ADDR_W-1:0]         o_head_addr,
   output logic [DATA_W-1:0]         o_head_data,
   output logic [PTR_W-1:0]          o_head,
   output logic [PTR_W:0]            o_count,
   output logic [DEPTH-1:0]          o_valid,
   output logic [DEPTH*ADDR_W-1:0]   o_entry_addr,
   output logic [DEPTH*DATA_W-1:0]   o_entry_data
);

   logic [ADDR_W-1:0] r_addr [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [PTR_W:0]    r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_tail <= r_tail + 1'b1;
         if (i_pop)  r_head <= r_head + 1'b1;
         r_count <= r_count + (PTR_W+1)'(i_push) - (PTR_W+1)'(i_pop);
      end
   end

   // Storage needs no reset: validity comes solely from head/count.
   always_ff @(posedge clk) begin
      if (i_push && !i_flush) begin
         r_addr[r_tail] <= i_addr;
         r_data[r_tail] <= i_data;
      end
   end

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] w_off;
      assign w_off        = PTR_W'(gi) - r_head;
      assign o_valid[gi]  = ({1'b0, w_off} < r_count);
      assign o_entry_addr[gi*ADDR_W +: ADDR_W] = r_addr[gi];
      assign o_entry_data[gi*DATA_W +: DATA_W] = r_data[gi];
   end

   assign o_head_addr = r_addr[r_head];
   assign o_head_data = r_data[r_head];
   assign o_head      = r_head;
   assign o_count     = r_count;

endmodule
`default_nettype wire

// File: rtl/reg_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : reg_writeback_ctrl
// Brief   : Queued register-file write sequencer with read-side bypass.
// Rev     : 1.0  initial release
// ============================================================================
module reg_writeback_ctrl
   import reg_writeback_ctrl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  logic              CLK,
   input  logic              CLR,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [1:0]        wb_dst_sel,
   input  logic [1:0]        wb_src_sel,
   input  logic [4:0]        rt,
   input  logic [4:0]        rd,
   input  logic [31:0]       alu_result,
   input  logic [31:0]       mem_data,
   input  logic [31:0]       pc_plus4,
   input  logic              drain_en,
   input  logic              flush,
   output logic [4:0]        WriteReg,
   output logic [31:0]       WriteData,
   output logic              WE,
   input  logic [4:0]        byp_addr,
   output logic              byp_hit,
   output logic [31:0]       byp_data,
   output logic [PTR_W:0]    pending
);

   logic [ADDR_W-1:0]       w_dst_addr;
   logic [DATA_W-1:0]       w_src_data;
   logic                    w_push;
   logic                    w_pop;
   logic [ADDR_W-1:0]       w_head_addr;
   logic [DATA_W-1:0]       w_head_data;
   logic [PTR_W-1:0]        w_head;
   logic [PTR_W:0]          w_count;
   logic [DEPTH-1:0]        w_valid;
   logic [DEPTH*ADDR_W-1:0] w_ent_addr;
   logic [DEPTH*DATA_W-1:0] w_ent_data;
   logic [PTR_W-1:0]        w_idx;
   logic                    r_live;

   always_comb begin
      case (dst_sel_e'(wb_dst_sel))
         DST_RT:  w_dst_addr = rt;
         DST_RD:  w_dst_addr = rd;
         DST_RA:  w_dst_addr = REG_RA;
         default: w_dst_addr = '0;
      endcase
      case (src_sel_e'(wb_src_sel))
         SRC_ALU: w_src_data = alu_result;
         SRC_MEM: w_src_data = mem_data;
         SRC_PC4: w_src_data = pc_plus4;
         default: w_src_data = '0;
      endcase
   end

   // r_live holds ready low until the first edge after reset release.
   assign wb_ready = r_live && !w_count[PTR_W] && !flush;
   assign w_push   = wb_valid && wb_ready && (w_dst_addr != '0);
   assign w_pop    = drain_en && (w_count != '0) && !flush;
   assign pending  = w_count;

   wb_queue #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_queue (
      .clk          (CLK),
      .rst          (CLR),
      .i_push       (w_push),
      .i_pop        (w_pop),
      .i_flush      (flush),
      .i_addr       (w_dst_addr),
      .i_data       (w_src_data),
      .o_head_addr  (w_head_addr),
      .o_head_data  (w_head_data),
      .o_head       (w_head),
      .o_count      (w_count),
      .o_valid      (w_valid),
      .o_entry_addr (w_ent_addr),
      .o_entry_data (w_ent_data)
   );

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_live    <= 1'b0;
         WE        <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_pop) begin
            WE        <= 1'b1;
            WriteReg  <= w_head_addr;
            WriteData <= w_head_data;
         end else begin
            WE <= 1'b0;
         end
      end
   end

   // Scan oldest to newest so the youngest match overrides; output reg is lowest.
   always_comb begin
      byp_hit  = 1'b0;
      byp_data = '0;
      w_idx    = '0;
      if (byp_addr != '0) begin
         if (WE && (WriteReg == byp_addr)) begin
            byp_hit  = 1'b1;
            byp_data = WriteData;
         end
         for (int k = 0; k < DEPTH; k++) begin
            w_idx = w_head + PTR_W'(k);
            if (w_valid[w_idx] && (w_ent_addr[int'(w_idx)*ADDR_W +: ADDR_W] == byp_addr)) begin
               byp_hit  = 1'b1;
               byp_data = w_ent_data[int'(w_idx)*DATA_W +: DATA_W];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_writeback_ctrl
// Brief   : Directed self-checking bench for reg_writeback_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
module tb_reg_writeback_ctrl;

   logic        CLK = 1'b0;
   logic        CLR;
   logic        wb_valid;
   logic        wb_ready;
   logic [1:0]  wb_dst_sel;
   logic [1:0]  wb_src_sel;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] alu_result;
   logic [31:0] mem_data;
   logic [31:0] pc_plus4;
   logic        drain_en;
   logic        flush;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic        WE;
   logic [4:0]  byp_addr;
   logic        byp_hit;
   logic [31:0] byp_data;
   logic [2:0]  pending;

   int n_vec = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   reg_writeback_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
      .CLK        (CLK),
      .CLR        (CLR),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_dst_sel (wb_dst_sel),
      .wb_src_sel (wb_src_sel),
      .rt         (rt),
      .rd         (rd),
      .alu_result (alu_result),
      .mem_data   (mem_data),
      .pc_plus4   (pc_plus4),
      .drain_en   (drain_en),
      .flush      (flush),
      .WriteReg   (WriteReg),
      .WriteData  (WriteData),
      .WE         (WE),
      .byp_addr   (byp_addr),
      .byp_hit    (byp_hit),
      .byp_data   (byp_data),
      .pending    (pending)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One-cycle request; inputs are dropped 1ns after the accepting edge.
   task automatic push(input logic [1:0] dsel, input logic [1:0] ssel,
                       input logic [4:0] t, input logic [4:0] d, input logic [31:0] v);
      wb_valid   = 1'b1;
      wb_dst_sel = dsel;
      wb_src_sel = ssel;
      rt         = t;
      rd         = d;
      alu_result = v;
      mem_data   = v;
      pc_plus4   = v;
      tick();
      wb_valid   = 1'b0;
   endtask

   task automatic chk_out(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
      chk({tag, ".WE"}, 32'(WE), 32'(we));
      if (we) begin
         chk({tag, ".WriteReg"}, 32'(WriteReg), 32'(a));
         chk({tag, ".WriteData"}, WriteData, d);
      end
   endtask

   initial begin
      CLR = 1'b1; wb_valid = 1'b0; wb_dst_sel = 2'b00; wb_src_sel = 2'b00;
      rt = '0; rd = '0; alu_result = '0; mem_data = '0; pc_plus4 = '0;
      drain_en = 1'b1; flush = 1'b0; byp_addr = '0;

      // Reset state
      tick(); tick();
      chk("rst.WE", 32'(WE), 32'd0);
      chk("rst.WriteReg", 32'(WriteReg), 32'd0);
      chk("rst.WriteData", WriteData, 32'd0);
      chk("rst.pending", 32'(pending), 32'd0);
      chk("rst.ready_low", 32'(wb_ready), 32'd0);
      CLR = 1'b0;
      #1;
      chk("rel.ready_still_low", 32'(wb_ready), 32'd0);
      tick();
      chk("rel.ready", 32'(wb_ready), 32'd1);

      // Single write: latency one edge, one-cycle WE pulse
      push(2'b01, 2'b00, 5'd0, 5'd5, 32'h1234);
      chk("single.pend", 32'(pending), 32'd1);
      chk("single.WE_N", 32'(WE), 32'd0);
      tick();
      chk_out("single.N1", 1'b1, 5'd5, 32'h1234);
      chk("single.pend0", 32'(pending), 32'd0);
      tick();
      chk("single.N2.WE", 32'(WE), 32'd0);
      chk("single.N2.hold", 32'(WriteReg), 32'd5);

      // Zero and none destinations are swallowed
      push(2'b01, 2'b00, 5'd7, 5'd0, 32'h99);
      chk("zero.pend", 32'(pending), 32'd0);
      push(2'b11, 2'b00, 5'd7, 5'd7, 32'h99);
      chk("none.pend", 32'(pending), 32'd0);
      chk("zero.WE", 32'(WE), 32'd0);
      tick();
      chk("none.WE", 32'(WE), 32'd0);

      // Full / stall, then ordered drain
      drain_en = 1'b0;
      push(2'b10, 2'b10, 5'd0, 5'd0, 32'h0040_0004);
      push(2'b00, 2'b01, 5'd8, 5'd0, 32'hDEAD_BEEF);
      push(2'b01, 2'b11, 5'd0, 5'd9, 32'h0000_0077);
      push(2'b01, 2'b00, 5'd0, 5'd8, 32'h0000_0055);
      chk("full.pend", 32'(pending), 32'd4);
      chk("full.ready", 32'(wb_ready), 32'd0);
      chk("full.WE", 32'(WE), 32'd0);
      push(2'b01, 2'b00, 5'd0, 5'd12, 32'h0000_0C0C);
      chk("full.reject", 32'(pending), 32'd4);
      byp_addr = 5'd8;  #1;
      chk("full.byp8.hit", 32'(byp_hit), 32'd1);
      chk("full.byp8.data", byp_data, 32'h55);
      byp_addr = 5'd9;  #1;
      chk("full.byp9.hit", 32'(byp_hit), 32'd1);
      chk("full.byp9.data", byp_data, 32'h0);
      byp_addr = 5'd31; #1;
      chk("full.byp31.data", byp_data, 32'h0040_0004);
      byp_addr = 5'd12; #1;
      chk("full.byp12.hit", 32'(byp_hit), 32'd0);
      drain_en = 1'b1;
      tick(); chk_out("drain1", 1'b1, 5'd31, 32'h0040_0004);
      tick(); chk_out("drain2", 1'b1, 5'd8,  32'hDEAD_BEEF);
      tick(); chk_out("drain3", 1'b1, 5'd9,  32'h0);
      tick(); chk_out("drain4", 1'b1, 5'd8,  32'h55);
      chk("drain4.pend", 32'(pending), 32'd0);
      tick(); chk("drain5.WE", 32'(WE), 32'd0);

      // Bypass youngest-wins across queue and output register
      drain_en = 1'b0;
      push(2'b01, 2'b00, 5'd0, 5'd8, 32'hAAAA);
      push(2'b01, 2'b00, 5'd0, 5'd8, 32'hBBBB);
      byp_addr = 5'd8; #1;
      chk("byp.q.hit", 32'(byp_hit), 32'd1);
      chk("byp.q.data", byp_data, 32'hBBBB);
      drain_en = 1'b1;
      tick();
      chk_out("byp.d1", 1'b1, 5'd8, 32'hAAAA);
      chk("byp.d1.data", byp_data, 32'hBBBB);
      tick();
      chk("byp.d2.hit", 32'(byp_hit), 32'd1);
      chk("byp.d2.data", byp_data, 32'hBBBB);
      tick();
      chk("byp.d3.hit", 32'(byp_hit), 32'd0);
      chk("byp.d3.data", byp_data, 32'h0);
      byp_addr = 5'd0; #1;
      chk("byp.zero.hit", 32'(byp_hit), 32'd0);
      chk("byp.zero.data", byp_data, 32'h0);

      // Flush wins over a simultaneous push and pop
      drain_en = 1'b0;
      push(2'b01, 2'b00, 5'd0, 5'd3, 32'h1);
      push(2'b01, 2'b00, 5'd0, 5'd4, 32'h2);
      chk("flush.pre", 32'(pending), 32'd2);
      wb_valid = 1'b1; wb_dst_sel = 2'b01; rd = 5'd5; alu_result = 32'h3;
      flush = 1'b1; drain_en = 1'b1; #1;
      chk("flush.ready", 32'(wb_ready), 32'd0);
      tick();
      wb_valid = 1'b0; flush = 1'b0;
      chk("flush.pend", 32'(pending), 32'd0);
      chk("flush.WE", 32'(WE), 32'd0);
      tick();
      chk("flush.after.WE", 32'(WE), 32'd0);
      chk("flush.after.pend", 32'(pending), 32'd0);

      // Asynchronous reset in the middle of a drain
      drain_en = 1'b0;
      push(2'b01, 2'b00, 5'd0, 5'd10, 32'hA);
      push(2'b01, 2'b00, 5'd0, 5'd11, 32'hB);
      push(2'b01, 2'b00, 5'd0, 5'd12, 32'hC);
      drain_en = 1'b1;
      tick();
      chk_out("mrst.d1", 1'b1, 5'd10, 32'hA);
      chk("mrst.d1.pend", 32'(pending), 32'd2);
      #2 CLR = 1'b1;
      #1;
      chk("mrst.WE", 32'(WE), 32'd0);
      chk("mrst.pend", 32'(pending), 32'd0);
      tick();
      CLR = 1'b0;
      tick();
      chk("mrst.rel.pend", 32'(pending), 32'd0);
      chk("mrst.rel.ready", 32'(wb_ready), 32'd1);
      chk("mrst.rel.WE", 32'(WE), 32'd0);
      tick();
      chk("mrst.rel2.WE", 32'(WE), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reg_writeback_ctrl.md
Name: reg_writeback_ctrl

Overview:
- Write-side sequencer for the CPU's 32x32 register file.
- Accepts writeback requests from the multicycle control path, resolves the destination register and data source, and buffers them in a small in-order queue.
- Drains one entry per cycle onto the register file's WriteReg/WriteData/WE write port.
- Provides a bypass lookup so the read path can see queued and in-flight writes that the register file does not yet hold.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, 2, pointer width; equals log2(DEPTH).

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- CLR  input  1  asynchronous, active-high reset.
- wb_valid  input  1  writeback request present.
- wb_ready  output  1  queue can accept a request this cycle.
- wb_dst_sel  input  2  destination select: 00 rt, 01 rd, 10 r31 (link), 11 no write.
- wb_src_sel  input  2  data select: 00 alu_result, 01 mem_data, 10 pc_plus4, 11 constant 0.
- rt  input  5  instruction rt field.
- rd  input  5  instruction rd field.
- alu_result  input  32  ALU output.
- mem_data  input  32  load data.
- pc_plus4  input  32  link address.
- drain_en  input  1  write port available; 0 stalls draining.
- flush  input  1  discard all queued and in-flight writes.
- WriteReg  output  5  register-file write address (registered).
- WriteData  output  32  register-file write data (registered).
- WE  output  1  register-file write enable (registered).
- byp_addr  input  5  read address to check against pending writes.
- byp_hit  output  1  a pending write targets byp_addr.
- byp_data  output  32  data of the youngest matching pending write.
- pending  output  PTR_W+1  occupancy count, excluding the in-flight output register.

Behaviour:
- Reset (CLR=1, asynchronous): count=0, head=tail=0, WE=0, WriteReg=0, WriteData=0. wb_ready rises on the first clock after CLR falls.
- Reset mid-operation discards all entries and any in-flight write. WE drops immediately with CLR.
- wb_ready = (count < DEPTH) and not flush. This is a combinational function of state, independent of wb_valid.
- Accept: wb_valid and wb_ready at posedge.
  - Destination resolves from wb_dst_sel.
  - If the resolved address is 0, or wb_dst_sel is 11, the request is accepted and then discarded (not enqueued, count unchanged).
  - Otherwise {addr, data} is written at tail, tail increments modulo DEPTH, and count increments.
- Drain, at posedge when drain_en=1 and count>0 (count evaluated before this edge's push): the head entry loads into WriteReg/WriteData, WE<=1, head increments modulo DEPTH, and count decrements.
- When draining does not occur, WE<=0. WriteReg and WriteData hold their values.
- A push and a pop in the same edge leave count unchanged. At full, a pop frees a slot but wb_ready stays 0 that cycle.
- A request accepted into an empty queue at edge N reaches WE=1 at edge N+1. The register file commits it on the following negedge. WE is high for exactly one cycle per entry.
- Ordering is strict FIFO. Two writes to the same register commit in request order.
- flush at posedge: count=0, head=tail=0, WE<=0. flush takes priority over push and pop in the same cycle; wb_ready=0 while flush=1.
- Bypass is combinational.
  - Candidates: all valid queue entries, plus the output register when WE=1.
  - Priority: the newest queue entry (tail-1 backwards to head), then the output register.
  - byp_addr=0 always gives byp_hit=0 and byp_data=0.
  - No hit gives byp_data=0.
- Empty queue with drain_en=1: WE=0, no state change.
- pending equals the count register.

Decomposition:
- Shared CPU package holds:
  - the dst select encodings (DST_RT, DST_RD, DST_RA, DST_NONE);
  - the src select encodings (SRC_ALU, SRC_MEM, SRC_PC4, SRC_ZERO);
  - the constant REG_RA=5'd31.
- One sub-module: wb_queue (parameterised DEPTH-entry FIFO of {5-bit addr, 32-bit data}) with push/pop/flush and exposed entry/valid vectors for the bypass search.
- Select muxes and bypass priority logic live in the top module.

Test Plan:
- Reset: assert CLR mid-drain with 3 entries queued -> WE=0 immediately; after release pending=0, wb_ready=1, and no further writes appear.
- Single write: dst_sel=01, rd=5, src_sel=00, alu_result=0x1234 at edge N -> edge N+1 gives WE=1, WriteReg=5, WriteData=0x1234; edge N+2 gives WE=0.
- Zero and none destinations: rd=0 with dst_sel=01, and any request with dst_sel=11 -> accepted, pending stays 0, WE never asserted.
- Full/stall: drain_en=0, push 4 requests -> wb_ready=0 and pending=4. Raise drain_en -> 4 consecutive WE pulses in order (r31←pc_plus4=0x400004, r8←mem_data=0xDEADBEEF, r9←0, r8←0x55).
- Bypass: queue r8=0xAAAA then r8=0xBBBB with drain stalled, byp_addr=8 -> hit with 0xBBBB. After draining both -> byp_hit=0. byp_addr=0 -> hit=0.
- Flush with simultaneous push: 2 queued, wb_valid=1, flush=1 -> wb_ready=0, pending=0 next cycle, WE=0, and the new request is not enqueued.
